// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_refill_arbiter                                                        |
// | Round-robin line-transfer sequencer between icache, dcache and memory.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_refill_arbiter #(
  parameter int MEM_LATENCY = 10,
  parameter int LINE_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_done,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int              C_CW   = $clog2(MEM_LATENCY) + 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_CW-1:0]       r_cnt;
  logic                  r_last_dc;   // port granted most recently; also the port being served
  logic                  r_stale;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  w_ic_vld;
  logic                  w_dc_vld;
  logic                  w_grant;
  logic                  w_grant_dc;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_sel_addr;

  // The cache just served still shows req for one cycle after its done pulse.
  assign w_ic_vld   = ic_req & ~(r_stale & ~r_last_dc);
  assign w_dc_vld   = dc_req & ~(r_stale & r_last_dc);
  assign w_last     = (r_cnt == C_LAST);
  assign w_sel_addr = w_grant_dc ? dc_addr : ic_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ic_vld || w_dc_vld) begin
          w_grant     = 1'b1;
          w_grant_dc  = w_dc_vld & (~w_ic_vld | ~r_last_dc);
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_last_dc <= 1'b1;
      r_stale   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_line    <= '0;
    end else begin
      r_stale <= (r_state == ST_DONE);
      if (w_grant) begin
        r_cnt     <= '0;
        r_last_dc <= w_grant_dc;
        r_we      <= w_grant_dc & dc_we;
        r_addr    <= {w_sel_addr[ADDR_WIDTH-1:3], 3'b000};
        r_wdata   <= w_grant_dc ? dc_wdata : '0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last && !r_we) begin
          r_line <= mem_rdata;
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign mem_en    = (r_state == ST_BUSY);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign line_out  = r_line;
  assign ic_done   = (r_state == ST_DONE) & ~r_last_dc;
  assign dc_done   = (r_state == ST_DONE) & r_last_dc;

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_refill_arbiter                                                     |
// | Self-checking bench: vector table, scoreboard and corner-case sequences.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_refill_arbiter;
  localparam int L = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [63:0] dc_wdata = '0;
  logic        dc_done;
  logic [63:0] line_out;
  logic        busy, mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  logic        ic_req1 = 1'b0;
  logic [31:0] ic_addr1 = '0;
  logic        ic_done1;
  logic        dc_req1 = 1'b0;
  logic        dc_we1 = 1'b0;
  logic [31:0] dc_addr1 = '0;
  logic [63:0] dc_wdata1 = '0;
  logic        dc_done1;
  logic [63:0] line_out1;
  logic        busy1, mem_en1, mem_we1;
  logic [31:0] mem_addr1;
  logic [63:0] mem_wdata1;
  logic [63:0] mem_rdata1 = '0;

  always #5 clk = ~clk;

  mem_refill_arbiter #(.MEM_LATENCY(L), .LINE_WIDTH(64), .ADDR_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_done(dc_done),
    .line_out(line_out), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_refill_arbiter #(.MEM_LATENCY(1), .LINE_WIDTH(64), .ADDR_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_done(ic_done1),
    .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1), .dc_done(dc_done1),
    .line_out(line_out1), .busy(busy1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  typedef struct {
    bit          dc;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [31:0] exp_addr;
    logic [63:0] exp_line;
  } vec_t;

  typedef struct {
    bit          dc;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] line;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] model_line = '0;
  int          en_cyc = 0;
  int          last_run = 0;
  bit          fld_bad = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input bit dc, input bit we, input logic [31:0] addr,
                                   input logic [63:0] wdata, input logic [63:0] rdata);
    exp_t e;
    e.dc    = dc;
    e.we    = we;
    e.addr  = addr & 32'hFFFF_FFF8;
    e.wdata = wdata;
    e.rdata = rdata;
    e.line  = we ? model_line : rdata;
    model_line = e.line;
    sb.push_back(e);
  endfunction

  // Memory model and completion monitor for the MEM_LATENCY=10 instance.
  always @(negedge clk) begin
    if (mem_en) begin
      en_cyc++;
    end else begin
      if (en_cyc != 0) last_run = en_cyc;
      en_cyc = 0;
    end
    mem_rdata = (mem_en && en_cyc == L && sb.size() > 0) ? sb[0].rdata : 64'hBAD0_BAD0_BAD0_BAD0;
    if (mem_en && sb.size() > 0) begin
      if (mem_addr !== sb[0].addr || mem_we !== sb[0].we ||
          (sb[0].we && mem_wdata !== sb[0].wdata)) fld_bad = 1'b1;
    end
    if (ic_done || dc_done) begin
      chk("done_exclusive", 64'(ic_done & dc_done), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual ic_done=%b dc_done=%b required none", ic_done, dc_done);
      end else begin
        mon_e = sb.pop_front();
        chk("done_port", 64'(dc_done), 64'(mon_e.dc));
        chk("line_out", line_out, mon_e.line);
        chk("mem_en_len", 64'(last_run), 64'(L));
        chk("req_fields", 64'(fld_bad), 64'd0);
        fld_bad = 1'b0;
      end
    end
  end

  // Assert the chosen requests, drop each one cycle after its done (like a cache would).
  task automatic run_reqs(input bit use_ic, input bit use_dc, output int t_ic, output int t_dc);
    int ic_drop;
    int dc_drop;
    int k;
    ic_drop = 0;
    dc_drop = 0;
    k = 0;
    t_ic = -1;
    t_dc = -1;
    ic_req = use_ic;
    dc_req = use_dc;
    while ((ic_req || dc_req) && k < 200) begin
      @(negedge clk);
      k++;
      if (ic_done && t_ic < 0) begin
        t_ic = k;
        ic_drop = 2;
      end else if (ic_drop > 0) begin
        ic_drop--;
        if (ic_drop == 0) ic_req = 1'b0;
      end
      if (dc_done && t_dc < 0) begin
        t_dc = k;
        dc_drop = 2;
      end else if (dc_drop > 0) begin
        dc_drop--;
        if (dc_drop == 0) dc_req = 1'b0;
      end
    end
    if (ic_req || dc_req) begin
      checks++;
      failures++;
      $display("FAIL timeout: actual ic_req=%b dc_req=%b still pending required all done", ic_req, dc_req);
      ic_req = 1'b0;
      dc_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int   t_ic, t_dc, cnt, k, en_cnt1, first_en1, done1_t, busy_cnt1;
    logic [31:0] addr_at_en1;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_1234, 64'h0, 64'hDEAD_BEEF_0123_4567, 32'h0000_1230, 64'hDEAD_BEEF_0123_4567};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0040, 64'h1111_2222_3333_4444, 64'h9999_9999_9999_9999, 32'h0000_0040, 64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 64'h0, 64'hA5A5_5A5A_C3C3_3C3C, 32'hFFFF_FFF8, 64'hA5A5_5A5A_C3C3_3C3C};
    tbl[3] = '{1'b0, 1'b0, 32'h8000_0007, 64'h0, 64'h0123_4567_89AB_CDEF, 32'h8000_0000, 64'h0123_4567_89AB_CDEF};
    tbl[4] = '{1'b1, 1'b1, 32'h1234_567C, 64'hFFFF_0000_FFFF_0000, 64'h7777_7777_7777_7777, 32'h1234_5678, 64'h0123_4567_89AB_CDEF};
    tbl[5] = '{1'b0, 1'b0, 32'h0000_0ABC, 64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 32'h0000_0AB8, 64'h0F0F_0F0F_F0F0_F0F0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_line_out", line_out, 64'd0);
    chk("rst_ic_done", 64'(ic_done), 64'd0);
    chk("rst_dc_done", 64'(dc_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie right after reset: icache first, dcache right after icache's IDLE cycle
    ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0208; dc_we = 1'b0; dc_wdata = 64'h0;
    push_exp(1'b0, 1'b0, ic_addr, 64'h0, 64'h1000_0000_0000_0001);
    push_exp(1'b1, 1'b0, dc_addr, 64'h0, 64'h2000_0000_0000_0002);
    run_reqs(1'b1, 1'b1, t_ic, t_dc);
    chk("tie1_ic_time", 64'(t_ic), 64'(L + 1));
    chk("tie1_dc_time", 64'(t_dc), 64'(2 * L + 3));
    chk("tie1_idle_after", 64'(busy), 64'd0);
    @(negedge clk);

    // Second tie after dcache served: icache again
    ic_addr = 32'h0000_0300; dc_addr = 32'h0000_0410;
    push_exp(1'b0, 1'b0, ic_addr, 64'h0, 64'h3000_0000_0000_0003);
    push_exp(1'b1, 1'b0, dc_addr, 64'h0, 64'h4000_0000_0000_0004);
    run_reqs(1'b1, 1'b1, t_ic, t_dc);
    chk("tie2_ic_time", 64'(t_ic), 64'(L + 1));
    chk("tie2_dc_time", 64'(t_dc), 64'(2 * L + 3));
    @(negedge clk);

    // icache alone, then a tie must now favour dcache
    ic_addr = 32'h0000_0500;
    push_exp(1'b0, 1'b0, ic_addr, 64'h0, 64'h5000_0000_0000_0005);
    run_reqs(1'b1, 1'b0, t_ic, t_dc);
    @(negedge clk);
    ic_addr = 32'h0000_0608; dc_addr = 32'h0000_0718; dc_we = 1'b1; dc_wdata = 64'hCAFE_F00D_CAFE_F00D;
    push_exp(1'b1, 1'b1, dc_addr, dc_wdata, 64'h6000_0000_0000_0006);
    push_exp(1'b0, 1'b0, ic_addr, 64'h0, 64'h7000_0000_0000_0007);
    run_reqs(1'b1, 1'b1, t_ic, t_dc);
    chk("tie3_dc_time", 64'(t_dc), 64'(L + 1));
    chk("tie3_ic_time", 64'(t_ic), 64'(2 * L + 3));
    @(negedge clk);

    // Vector table: single-port transactions, stale req held one cycle past done
    for (int i = 0; i < 6; i++) begin
      ic_addr  = tbl[i].addr;
      dc_addr  = tbl[i].addr;
      dc_wdata = tbl[i].wdata;
      dc_we    = tbl[i].dc ? tbl[i].we : 1'b1;
      sb.push_back('{tbl[i].dc, tbl[i].we, tbl[i].exp_addr, tbl[i].wdata, tbl[i].rdata, tbl[i].exp_line});
      model_line = tbl[i].exp_line;
      run_reqs(!tbl[i].dc, tbl[i].dc, t_ic, t_dc);
      chk("vec_latency", 64'(tbl[i].dc ? t_dc : t_ic), 64'(L + 1));
      chk("vec_stale_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end

    // MEM_LATENCY=1 build
    dc_addr1 = 32'h0000_008F;
    dc_req1  = 1'b1;
    en_cnt1 = 0; first_en1 = -1; done1_t = -1; busy_cnt1 = 0; addr_at_en1 = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      mem_rdata1 = mem_en1 ? 64'h5555_AAAA_5555_AAAA : 64'hBAD1_BAD1_BAD1_BAD1;
      if (mem_en1) begin
        en_cnt1++;
        if (first_en1 < 0) begin
          first_en1 = j;
          addr_at_en1 = mem_addr1;
        end
      end
      if (dc_done1 && done1_t < 0) done1_t = j;
      if (busy1) busy_cnt1++;
      if (j == 4) dc_req1 = 1'b0;
    end
    chk("lat1_en_cycles", 64'(en_cnt1), 64'd1);
    chk("lat1_en_first", 64'(first_en1), 64'd1);
    chk("lat1_done_cycle", 64'(done1_t), 64'd2);
    chk("lat1_busy_cycles", 64'(busy_cnt1), 64'd2);
    chk("lat1_addr", 64'(addr_at_en1), 64'h88);
    chk("lat1_line_out", line_out1, 64'h5555_AAAA_5555_AAAA);

    // Reset in the 5th BUSY cycle of a read aborts it
    ic_addr = 32'h0000_0900;
    push_exp(1'b0, 1'b0, ic_addr, 64'h0, 64'h8888_0000_8888_0000);
    ic_req = 1'b1;
    cnt = 0;
    k = 0;
    while (cnt < 5 && k < 50) begin
      @(negedge clk);
      k++;
      if (mem_en) cnt++;
    end
    chk("abort_reached_busy", 64'(cnt), 64'd5);
    rst_n = 1'b0;
    sb.delete();
    model_line = '0;
    @(negedge clk);
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_line_out", line_out, 64'd0);
    ic_req = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 2 * L; j++) begin
      @(negedge clk);
      if (ic_done || dc_done) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Sequences line-sized transfers between the shared 64-bit main memory and its two clients: instruction-cache miss refills and data-cache refills/writebacks. It arbitrates round-robin between the two and holds the memory request for a fixed latency. It returns each read line with a one-cycle completion pulse, which drives the caches' `countdone` fill input. The block sits between the fetch-stage cache, the memory-stage cache, and the single memory port.

## Interface
- MEM_LATENCY, 10, cycles memory request held before read data is valid (≥1)
- LINE_WIDTH, 64, bits per cache line / memory word
- ADDR_WIDTH, 32, byte address width

- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- ic_req  input  1  icache miss pending (level; held until ic_done)
- ic_addr  input  ADDR_WIDTH  icache miss byte address
- ic_done  output  1  one-cycle pulse: line_out valid for icache
- dc_req  input  1  dcache transfer pending (level; held until dc_done)
- dc_we  input  1  1 = writeback of dc_wdata, 0 = refill
- dc_addr  input  ADDR_WIDTH  dcache byte address
- dc_wdata  input  LINE_WIDTH  writeback line
- dc_done  output  1  one-cycle pulse: dcache transfer complete
- line_out  output  LINE_WIDTH  last line read from memory (registered)
- busy  output  1  transaction in progress (state ≠ IDLE)
- mem_en  output  1  memory request active
- mem_we  output  1  memory write
- mem_addr  output  ADDR_WIDTH  line-aligned address, bits [2:0] = 0
- mem_wdata  output  LINE_WIDTH  write data
- mem_rdata  input  LINE_WIDTH  memory read data, valid in the MEM_LATENCY-th cycle of mem_en

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Evaluates the masked requests. If any is present, grants one and latches addr (with [2:0] forced to 0), we, and wdata. Clears the counter and moves to BUSY.
  - Arbitration: single requester wins outright. When both request, the port not granted last time wins (`last_grant` bit, updated on every grant).
  - Stale-request mask: in the first IDLE cycle after DONE, the req of the port just served is ignored. Caches deassert req one cycle late because their hit flag is registered.
- BUSY:
  - mem_en=1; mem_we = latched we (icache always 0); mem_addr and mem_wdata are stable for the whole state.
  - The counter increments each cycle. In the cycle where counter == MEM_LATENCY-1, line_out <= mem_rdata if the transaction is a read, and the FSM moves to DONE.
  - On a write, line_out is unchanged.
- DONE: mem_en=0. The granted port's done output is 1 for exactly this cycle, then the FSM returns to IDLE.
- Request changes during BUSY/DONE (deassert, address change) are ignored. The latched transaction completes and its done still pulses.
- Counter width is $clog2(MEM_LATENCY)+1 and never wraps, because it is cleared on grant.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, last_grant = dcache (so icache wins the first tie). All outputs are 0, including line_out, ic_done, dc_done, busy, mem_en, mem_we, mem_addr, and mem_wdata.
- Reset mid-transaction aborts it: mem_en is 0 from the next cycle, and no done pulse is issued.
- Request seen in IDLE in cycle 0:
  - mem_en is high in cycles 1..MEM_LATENCY.
  - line_out is updated at the end of cycle MEM_LATENCY.
  - done is high in cycle MEM_LATENCY+1.
  - IDLE is in cycle MEM_LATENCY+2.
- Back-to-back: with the other port pending, the next grant occurs at the end of cycle MEM_LATENCY+2, and mem_en reasserts in cycle MEM_LATENCY+3. The same port re-requesting waits one extra cycle because of the mask.
- mem_en has a minimum one-cycle low gap between transactions.
- ic_done and dc_done are never high in the same cycle.

## Test plan
- Reset then icache miss, ic_addr=0x0000_1234, MEM_LATENCY=10, memory returns 0xDEAD_BEEF_0123_4567:
  - required: mem_addr=0x0000_1230 with mem_en high for 10 cycles, ic_done high in cycle 11, line_out=0xDEAD_BEEF_0123_4567.
- ic_req and dc_req both rise in the same cycle after reset:
  - required: icache granted first; dcache granted at the end of icache's IDLE cycle; next simultaneous tie goes to icache again (alternation).
- dcache writeback, dc_we=1, dc_addr=0x40, dc_wdata=0x1111_2222_3333_4444:
  - required: mem_we=1, mem_wdata latched for 10 cycles, dc_done pulse, line_out unchanged.
- icache holds ic_req high one cycle after ic_done (stale):
  - required: no second icache grant; busy stays 0.
- rst_n low in cycle 5 of a BUSY read:
  - required: mem_en=0 and busy=0 the next cycle, no done pulse, line_out=0.
- MEM_LATENCY=1 build:
  - required: mem_en for exactly 1 cycle, done in cycle 2.
